// File: rtl/simple_writeback.sv
// simple_writeback: in-order write-back queue between the ALU and the register file,
// with a pending-write scoreboard and RUN/DRAIN/HALT stop control.
// Optional feature: define SIMPLE_WB_BYPASS_EN to add byp_data_o (youngest matching data).
module simple_writeback #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    wb_valid_i,
    output logic                    wb_ready_o,
    input  logic [REG_ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]       wb_data_i,
    input  logic                    stop_i,
    output logic                    rf_wen_o,
    output logic [REG_ADDR_W-1:0]   rf_waddr_o,
    output logic [DATA_W-1:0]       rf_wdata_o,
    input  logic                    rf_wack_i,
    input  logic [REG_ADDR_W-1:0]   pend_addr_i,
    output logic                    pend_hit_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    halted_o
`ifdef SIMPLE_WB_BYPASS_EN
    ,
    output logic [DATA_W-1:0]       byp_data_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [REG_ADDR_W-1:0]  addr_mem_q [DEPTH];
    logic [DATA_W-1:0]      data_mem_q [DEPTH];
    logic                   rf_wen_q, rf_wen_d;
    logic [REG_ADDR_W-1:0]  head_addr_q, head_addr_d;
    logic [DATA_W-1:0]      head_data_q, head_data_d;
    logic                   ready_s;
    logic                   push_s;
    logic                   enq_s;
    logic                   pop_s;
    logic [PTR_W-1:0]       slot_s [DEPTH];
    logic [DEPTH-1:0]       match_s;

    // Handshake: writes to r0 complete the handshake but are never stored.
    always_comb begin
        ready_s = (count_q < CNT_W'(DEPTH)) && (state_q == ST_RUN);
        push_s  = wb_valid_i && ready_s && n_reset;
        enq_s   = push_s && (wb_addr_i != {REG_ADDR_W{1'b0}});
        pop_s   = rf_wen_q && rf_wack_i;
    end

    // Pointer, occupancy and registered head-of-queue next state.
    always_comb begin
        wr_ptr_d    = enq_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d     = count_q + {{PTR_W{1'b0}}, enq_s} - {{PTR_W{1'b0}}, pop_s};
        rf_wen_d    = (count_d != {CNT_W{1'b0}});
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        // The new head is the entry being written this cycle when it lands on the read slot.
        if (enq_s && (wr_ptr_q == rd_ptr_d)) begin
            head_addr_d = wb_addr_i;
            head_data_d = wb_data_i;
        end else if (count_d != {CNT_W{1'b0}}) begin
            head_addr_d = addr_mem_q[rd_ptr_d];
            head_data_d = data_mem_q[rd_ptr_d];
        end else begin
            head_addr_d = head_addr_q;
            head_data_d = head_data_q;
        end
    end

    // Stop control: stop only acts in RUN; HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = stop_i ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = ((count_q == {CNT_W{1'b0}}) && !pop_s) ? ST_HALT : ST_DRAIN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            rf_wen_q    <= 1'b0;
            head_addr_q <= {REG_ADDR_W{1'b0}};
            head_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rf_wen_q    <= rf_wen_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
        end
    end

    // Queue storage; occupancy alone defines which slots are valid.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            addr_mem_q[wr_ptr_q] <= wb_addr_i;
            data_mem_q[wr_ptr_q] <= wb_data_i;
        end
    end

    // Scoreboard: slot g is the g-th oldest entry, valid when g < count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign slot_s[g]  = rd_ptr_q + PTR_W'(g);
        assign match_s[g] = (CNT_W'(g) < count_q)
                         && (addr_mem_q[slot_s[g]] == pend_addr_i)
                         && (pend_addr_i != {REG_ADDR_W{1'b0}});
    end

`ifdef SIMPLE_WB_BYPASS_EN
    logic [DATA_W-1:0] byp_s;

    // Bypass: scan oldest to youngest so the youngest match wins.
    always_comb begin
        byp_s = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            byp_s = match_s[k] ? data_mem_q[slot_s[k]] : byp_s;
        end
    end

    assign byp_data_o = byp_s;
`endif

    assign wb_ready_o = ready_s && n_reset;
    assign rf_wen_o   = rf_wen_q && n_reset;
    assign rf_waddr_o = head_addr_q;
    assign rf_wdata_o = head_data_q;
    assign pend_hit_o = (|match_s) && n_reset;
    assign count_o    = count_q;
    assign halted_o   = (state_q == ST_HALT) && n_reset;

endmodule

// File: tb/tb_simple_writeback.sv
// Self-checking bench for simple_writeback: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_simple_writeback;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = 3;

    logic                   clk = 1'b0;
    logic                   n_reset;
    logic                   wb_valid_i;
    logic                   wb_ready_o;
    logic [REG_ADDR_W-1:0]  wb_addr_i;
    logic [DATA_W-1:0]      wb_data_i;
    logic                   stop_i;
    logic                   rf_wen_o;
    logic [REG_ADDR_W-1:0]  rf_waddr_o;
    logic [DATA_W-1:0]      rf_wdata_o;
    logic                   rf_wack_i;
    logic [REG_ADDR_W-1:0]  pend_addr_i;
    logic                   pend_hit_o;
    logic [CNT_W-1:0]       count_o;
    logic                   halted_o;
`ifdef SIMPLE_WB_BYPASS_EN
    logic [DATA_W-1:0]      byp_data_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the queue contents in retirement order and the stop state.
    logic [REG_ADDR_W-1:0]  m_addr [$];
    logic [DATA_W-1:0]      m_data [$];
    int                     m_state = 0; // 0 run, 1 drain, 2 halt

    always #5 clk = ~clk;

    simple_writeback #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .wb_valid_i (wb_valid_i),
        .wb_ready_o (wb_ready_o),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .stop_i     (stop_i),
        .rf_wen_o   (rf_wen_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o),
        .rf_wack_i  (rf_wack_i),
        .pend_addr_i(pend_addr_i),
        .pend_hit_o (pend_hit_o),
        .count_o    (count_o),
        .halted_o   (halted_o)
`ifdef SIMPLE_WB_BYPASS_EN
        ,
        .byp_data_o (byp_data_o)
`endif
    );

    function automatic bit exp_hit(input logic [REG_ADDR_W-1:0] a);
        exp_hit = 1'b0;
        foreach (m_addr[i]) if (a != 0 && m_addr[i] == a) exp_hit = 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] exp_byp(input logic [REG_ADDR_W-1:0] a);
        exp_byp = '0;
        foreach (m_addr[i]) if (a != 0 && m_addr[i] == a) exp_byp = m_data[i];
    endfunction

    // Advance one clock, updating the model from the inputs presented at this edge.
    task automatic step();
        int sz;
        bit pop, push;
        sz   = m_addr.size();
        pop  = (sz != 0) && rf_wack_i;
        push = wb_valid_i && (sz < DEPTH) && (m_state == 0);
        if (!n_reset) begin
            m_addr.delete();
            m_data.delete();
            m_state = 0;
        end else begin
            if (pop) begin
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
            end
            if (push && wb_addr_i != 0) begin
                m_addr.push_back(wb_addr_i);
                m_data.push_back(wb_data_i);
            end
            if (m_state == 0 && stop_i) m_state = 1;
            else if (m_state == 1 && sz == 0) m_state = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid_i  = 1'b0;
        wb_addr_i   = '0;
        wb_data_i   = '0;
        stop_i      = 1'b0;
        rf_wack_i   = 1'b0;
        pend_addr_i = '0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        idle_inputs();
        pend_addr_i = 5'd3;
        step();
        step();
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", count_o); end
        n_cmp++; if (rf_wen_o !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b exp 0", rf_wen_o); end
        n_cmp++; if (wb_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b exp 0", wb_ready_o); end
        n_cmp++; if (pend_hit_o !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b exp 0", pend_hit_o); end
        n_cmp++; if (halted_o !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b exp 0", halted_o); end
        n_cmp++; if (rf_waddr_o !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d exp 0", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %0h exp 0", rf_wdata_o); end
        n_reset = 1'b1;
        step();
        n_cmp++; if (wb_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b exp 1", wb_ready_o); end
    endtask

    task automatic test_single_write();
        rf_wack_i  = 1'b1;
        wb_valid_i = 1'b1;
        wb_addr_i  = 5'd3;
        wb_data_i  = 32'h0000_00AA;
        step();
        wb_valid_i = 1'b0;
        #1;
        n_cmp++; if (rf_wen_o !== 1'b1) begin n_err++; $display("FAIL single_wen: got %b exp 1", rf_wen_o); end
        n_cmp++; if (rf_waddr_o !== 5'd3) begin n_err++; $display("FAIL single_waddr: got %0d exp 3", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== 32'h0000_00AA) begin n_err++; $display("FAIL single_wdata: got %0h exp aa", rf_wdata_o); end
        step();
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL single_count: got %0d exp 0", count_o); end
        n_cmp++; if (rf_wen_o !== 1'b0) begin n_err++; $display("FAIL single_wen_after: got %b exp 0", rf_wen_o); end
        rf_wack_i = 1'b0;
    endtask

    task automatic test_full();
        rf_wack_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid_i = 1'b1;
            wb_addr_i  = 5'(i);
            wb_data_i  = 32'h100 + 32'(i);
            step();
        end
        wb_addr_i = 5'd5;
        wb_data_i = 32'h105;
        #1;
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d exp 4", count_o); end
        n_cmp++; if (wb_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b exp 0", wb_ready_o); end
        n_cmp++; if (rf_waddr_o !== 5'd1) begin n_err++; $display("FAIL full_head: got %0d exp 1", rf_waddr_o); end
        rf_wack_i = 1'b1;
        step();
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL full_nopushthrough: got %0d exp 3", count_o); end
        n_cmp++; if (wb_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready_after_ack: got %b exp 1", wb_ready_o); end
        rf_wack_i = 1'b0;
        step();
        wb_valid_i = 1'b0;
        #1;
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_r5_accepted: got %0d exp 4", count_o); end
        rf_wack_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_cmp++; if (rf_waddr_o !== 5'(i) || rf_wdata_o !== (32'h100 + 32'(i))) begin
                n_err++; $display("FAIL full_order: got r%0d=%0h exp r%0d=%0h", rf_waddr_o, rf_wdata_o, i, 32'h100 + 32'(i));
            end
            step();
        end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL full_drained: got %0d exp 0", count_o); end
        rf_wack_i = 1'b0;
    endtask

    task automatic test_r0();
        rf_wack_i  = 1'b0;
        wb_valid_i = 1'b1;
        wb_addr_i  = 5'd0;
        wb_data_i  = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (wb_ready_o !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %b exp 1", wb_ready_o); end
        step();
        wb_valid_i  = 1'b0;
        pend_addr_i = 5'd0;
        #1;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL r0_count: got %0d exp 0", count_o); end
        n_cmp++; if (rf_wen_o !== 1'b0) begin n_err++; $display("FAIL r0_wen: got %b exp 0", rf_wen_o); end
        n_cmp++; if (pend_hit_o !== 1'b0) begin n_err++; $display("FAIL r0_hit: got %b exp 0", pend_hit_o); end
    endtask

    task automatic test_pending();
        rf_wack_i  = 1'b0;
        wb_valid_i = 1'b1;
        wb_addr_i  = 5'd7;
        wb_data_i  = 32'h11;
        step();
        wb_data_i  = 32'h22;
        step();
        wb_valid_i  = 1'b0;
        pend_addr_i = 5'd7;
        #1;
        n_cmp++; if (pend_hit_o !== 1'b1) begin n_err++; $display("FAIL pend_hit: got %b exp 1", pend_hit_o); end
`ifdef SIMPLE_WB_BYPASS_EN
        n_cmp++; if (byp_data_o !== 32'h22) begin n_err++; $display("FAIL pend_byp: got %0h exp 22", byp_data_o); end
`endif
        n_cmp++; if (rf_wdata_o !== 32'h11) begin n_err++; $display("FAIL pend_first: got %0h exp 11", rf_wdata_o); end
        pend_addr_i = 5'd8;
        #1;
        n_cmp++; if (pend_hit_o !== 1'b0) begin n_err++; $display("FAIL pend_miss: got %b exp 0", pend_hit_o); end
        pend_addr_i = 5'd7;
        rf_wack_i   = 1'b1;
        step();
        n_cmp++; if (rf_wdata_o !== 32'h22) begin n_err++; $display("FAIL pend_second: got %0h exp 22", rf_wdata_o); end
        step();
        n_cmp++; if (pend_hit_o !== 1'b0) begin n_err++; $display("FAIL pend_cleared: got %b exp 0", pend_hit_o); end
        rf_wack_i = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wb_valid_i  = 1'($urandom_range(0, 1));
            wb_addr_i   = 5'($urandom_range(0, 7));
            wb_data_i   = $urandom;
            rf_wack_i   = ($urandom_range(0, 2) == 0);
            pend_addr_i = 5'($urandom_range(0, 7));
            #1;
            n_cmp++; if (count_o !== 3'(m_addr.size())) begin n_err++; $display("FAIL rand_count c%0d: got %0d exp %0d", c, count_o, m_addr.size()); end
            n_cmp++; if (wb_ready_o !== (m_addr.size() < DEPTH)) begin n_err++; $display("FAIL rand_ready c%0d: got %b", c, wb_ready_o); end
            n_cmp++; if (rf_wen_o !== (m_addr.size() != 0)) begin n_err++; $display("FAIL rand_wen c%0d: got %b", c, rf_wen_o); end
            n_cmp++; if (pend_hit_o !== exp_hit(pend_addr_i)) begin n_err++; $display("FAIL rand_hit c%0d: got %b exp %b", c, pend_hit_o, exp_hit(pend_addr_i)); end
`ifdef SIMPLE_WB_BYPASS_EN
            n_cmp++; if (byp_data_o !== exp_byp(pend_addr_i)) begin n_err++; $display("FAIL rand_byp c%0d: got %0h exp %0h", c, byp_data_o, exp_byp(pend_addr_i)); end
`endif
            if (m_addr.size() != 0) begin
                n_cmp++; if (rf_waddr_o !== m_addr[0] || rf_wdata_o !== m_data[0]) begin
                    n_err++; $display("FAIL rand_head c%0d: got r%0d=%0h exp r%0d=%0h", c, rf_waddr_o, rf_wdata_o, m_addr[0], m_data[0]);
                end
            end
            step();
        end
        idle_inputs();
        rf_wack_i = 1'b1;
        for (int c = 0; c < 6; c++) step();
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rand_drain: got %0d exp 0", count_o); end
        rf_wack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        rf_wack_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wb_valid_i = 1'b1;
            wb_addr_i  = 5'(10 + i);
            wb_data_i  = 32'hA0 + 32'(i);
            step();
        end
        wb_valid_i = 1'b0;
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL rmid_filled: got %0d exp 3", count_o); end
        n_reset = 1'b0;
        step();
        n_reset   = 1'b1;
        rf_wack_i = 1'b1;
        #1;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d exp 0", count_o); end
        n_cmp++; if (wb_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b exp 1", wb_ready_o); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rf_wen_o !== 1'b0) begin n_err++; $display("FAIL rmid_wen cycle %0d: got %b exp 0", i, rf_wen_o); end
            step();
        end
        rf_wack_i = 1'b0;
    endtask

    task automatic test_stop_drain();
        rf_wack_i = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            wb_valid_i = 1'b1;
            wb_addr_i  = 5'(20 + i);
            wb_data_i  = 32'hC0 + 32'(i);
            step();
        end
        wb_valid_i = 1'b0;
        stop_i     = 1'b1;
        step();
        stop_i     = 1'b0;
        wb_valid_i = 1'b1;
        wb_addr_i  = 5'd30;
        #1;
        n_cmp++; if (wb_ready_o !== 1'b0) begin n_err++; $display("FAIL stop_ready: got %b exp 0", wb_ready_o); end
        n_cmp++; if (rf_waddr_o !== 5'd21) begin n_err++; $display("FAIL stop_first: got %0d exp 21", rf_waddr_o); end
        rf_wack_i = 1'b1;
        step();
        n_cmp++; if (rf_waddr_o !== 5'd22 || rf_wen_o !== 1'b1) begin n_err++; $display("FAIL stop_second: got r%0d wen %b exp r22 wen 1", rf_waddr_o, rf_wen_o); end
        step();
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL stop_empty: got %0d exp 0", count_o); end
        n_cmp++; if (halted_o !== 1'b0) begin n_err++; $display("FAIL stop_halt_early: got %b exp 0", halted_o); end
        step();
        n_cmp++; if (halted_o !== 1'b1) begin n_err++; $display("FAIL stop_halted: got %b exp 1", halted_o); end
        stop_i = 1'b1;
        step();
        step();
        n_cmp++; if (halted_o !== 1'b1 || count_o !== 3'd0) begin n_err++; $display("FAIL stop_stay_halt: got halted %b count %0d exp 1 0", halted_o, count_o); end
        idle_inputs();
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        #1;
        n_cmp++; if (halted_o !== 1'b0 || wb_ready_o !== 1'b1) begin n_err++; $display("FAIL stop_reset_exit: got halted %b ready %b exp 0 1", halted_o, wb_ready_o); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full();
        test_r0();
        test_pending();
        test_random();
        test_reset_mid();
        test_stop_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
